fmap_loader: RTL and testbench
==============================

Name: fmap_loader

Overview:
- Sequential producer for the binary 3x3 convolution stage.
- Accepts a binarized feature map as a stream of WORD_W-bit beats over valid/ready.
- Packs the beats into IC flattened IMG_SIZE*IMG_SIZE bitmaps and presents them, held stable, to the conv core's image input with a valid/ack handshake.
- Sits between the input/previous-layer buffer and the combinational conv core.

Parameters:
- IC, 8, number of input channels (bitmaps per frame).
- IMG_SIZE, 30, image side length in pixels; N = IMG_SIZE*IMG_SIZE bits per channel.
- WORD_W, 8, pixel bits per input beat; 1 <= WORD_W <= N.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous abort; discards the partial frame.
- in_data  input  WORD_W  pixel bits; bit i maps to pixel index pix_idx+i.
- in_valid  input  1  beat valid.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- img_out  output  [N-1:0] x [0:IC-1]  packed bitmaps, pixel (r,c) at bit r*IMG_SIZE+c, feeds the conv image input.
- img_valid  output  1  img_out holds a complete frame.
- img_ack  input  1  consumer has finished with the frame; release it.

Behaviour:
- Pixel order: channel-major, then row-major, column ascending.
- Beat alignment: each channel starts on a fresh beat.
  - BPC = ceil(N/WORD_W) beats per channel; frame = IC*BPC beats.
  - Last beat of a channel uses only N - (BPC-1)*WORD_W low bits; upper bits ignored, never written past bit N-1.
  - Defaults: BPC = 113, last beat uses bits [3:0], frame = 904 beats.
- Counters:
  - beat_cnt: $clog2(BPC) bits, wraps to 0 at end of channel.
  - ch_cnt: $clog2(IC) bits (min 1).
  - pix_idx = beat_cnt*WORD_W, computed at $clog2(N+WORD_W) width.
- FSM, two states:
  - LOAD: in_ready=1, img_valid=0. Each accepted beat writes its bits into img_out[ch_cnt] and advances counters. On the final beat of channel IC-1, go to FULL next cycle. No other bits change.
  - FULL: in_ready=0, img_valid=1, img_out held stable. in_valid is ignored. When img_ack=1, go to LOAD and zero the counters. The next frame may be accepted on the following cycle.
- Latency: img_valid rises the cycle after the last beat handshake.
- img_ack is ignored in LOAD.
- Bitmap contents are not cleared between frames; every bit is overwritten by the next frame.
- clear:
  - In LOAD: zero counters, stay in LOAD; any beat in the same cycle is dropped.
  - In FULL: same effect as img_ack.
  - clear and img_ack together: treated as a single release.
- rst: state=LOAD, counters=0, img_out all zeros, in_ready=1 from the first cycle after reset, img_valid=0.
  - Reset mid-load or mid-FULL behaves identically and discards the frame.
- in_ready depends only on state, never combinationally on in_valid.

Optional Feature:
- FMAP_LOADER_DBL_BUF_EN.
- Defined: two banks (A, B).
  - img_out shows the presented bank.
  - While a frame is presented, loading continues into the other bank; in_ready=0 only when both banks are full.
  - On img_ack, if the other bank is full, swap and keep img_valid=1 with no gap cycle; otherwise img_valid=0 until that bank completes.
  - clear discards the loading bank only.
  - rst empties both banks.
- Undefined: single bank, exact behaviour above.

Decomposition:
- Package fmap_pkg:
  - state enum (LOAD, FULL);
  - localparam functions for BPC, last-beat valid width and counter widths;
  - bank-select typedef.
- One sub-module: fmap_bank, an IC x N register array with a beat write port (channel, pix_idx, data, valid-bit mask) and full read-out. Instantiated once, or twice under FMAP_LOADER_DBL_BUF_EN.

Test Plan:
- Basic frame, defaults: stream 904 beats, beat k = k[7:0], in_valid held high. Expect img_valid=1 the cycle after beat 903. img_out[c] bit j must equal beat (c*113 + j/8) bit (j%8).
- Last-beat masking: send 0xFF on every last-of-channel beat. Expect bits 896..899 = 1, no write into the next channel, ch_cnt advances correctly.
- Backpressure and gaps: random in_valid gaps with 20 extra beats after frame complete. Expect in_ready=0 in FULL, extra beats not consumed, img_out unchanged until img_ack. After ack, the next 904 beats form frame 2.
- clear mid-load: clear after beat 300, then a full frame of all-ones. Expect img_valid after exactly 904 further beats and all bits 1.
- rst during FULL and during load (beat 500). Expect img_valid=0, in_ready=1 and img_out all zeros next cycle; a subsequent full frame loads correctly.
- With FMAP_LOADER_DBL_BUF_EN, two back-to-back frames, ack delayed 2000 cycles. Expect in_ready to stay 1 through frame 2's load and drop after frame 2 completes. On ack, img_valid stays 1 and img_out switches to frame 2 the next cycle.

Source files
------------

// File: rtl/fmap_pkg.sv
// Shared types and sizing helpers for the feature-map loader.
package fmap_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } state_t;

  typedef enum logic {
    BANK_A = 1'b0,
    BANK_B = 1'b1
  } bank_sel_t;

  // Beats needed to carry one channel of n pixels, w pixels per beat.
  function automatic int calc_bpc(input int n, input int w);
    return (n + w - 1) / w;
  endfunction

  // Number of meaningful low bits in the last beat of a channel.
  function automatic int calc_last_w(input int n, input int w);
    return n - (calc_bpc(n, w) - 1) * w;
  endfunction

  // Counter width able to index v items, never narrower than one bit.
  function automatic int cnt_w(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/fmap_loader_if.sv
// Beat stream in, packed image out. The loader sits on the slave modport;
// the feeding buffer / conv core side uses master.
interface fmap_loader_if #(
  parameter int IC       = 8,
  parameter int IMG_SIZE = 30,
  parameter int WORD_W   = 8
);
  localparam int N = IMG_SIZE * IMG_SIZE;

  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      img_out [0:IC-1];
  logic              img_valid;
  logic              img_ack;

  modport master (
    output in_data, in_valid, img_ack,
    input  in_ready, img_out, img_valid
  );

  modport slave (
    input  in_data, in_valid, img_ack,
    output in_ready, img_out, img_valid
  );
endinterface

// File: rtl/fmap_bank.sv
// One IC x N bitmap store. A beat writes the masked bits of wr_data into
// channel wr_ch starting at pixel wr_pix; every channel is always readable.
module fmap_bank #(
  parameter int IC     = 8,
  parameter int N      = 900,
  parameter int WORD_W = 8,
  parameter int CH_W   = 3,
  parameter int PIX_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [PIX_W-1:0]  wr_pix,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [WORD_W-1:0] wr_mask,
  output logic [N-1:0]      rd_img [0:IC-1]
);

  logic [N-1:0] sh_mask;
  logic [N-1:0] sh_data;

  // Align the beat and its mask to the channel's pixel position.
  always_comb begin
    sh_mask = N'({{N{1'b0}}, wr_mask} << wr_pix);
    sh_data = N'({{N{1'b0}}, (wr_data & wr_mask)} << wr_pix);
  end

  // Merge masked beat bits into the addressed channel; reset clears all.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < IC; c++) rd_img[c] <= '0;
    end else if (wr_en) begin
      rd_img[wr_ch] <= (rd_img[wr_ch] & ~sh_mask) | sh_data;
    end
  end

endmodule

// File: rtl/fmap_loader.sv
// Feature-map loader: packs WORD_W-bit beats into IC bitmaps of
// IMG_SIZE*IMG_SIZE pixels and holds them for the conv core until acked.
// Optional macro FMAP_LOADER_DBL_BUF_EN adds a second bank so loading can
// continue while a frame is presented.
module fmap_loader
  import fmap_pkg::*;
#(
  parameter int IC       = 8,
  parameter int IMG_SIZE = 30,
  parameter int WORD_W   = 8
) (
  input logic clk,
  input logic rst,
  input logic clear,
  fmap_loader_if.slave bus
);

  localparam int N      = IMG_SIZE * IMG_SIZE;
  localparam int BPC    = calc_bpc(N, WORD_W);
  localparam int LAST_W = calc_last_w(N, WORD_W);
  localparam int BEAT_W = cnt_w(BPC);
  localparam int CH_W   = cnt_w(IC);
  localparam int PIX_W  = $clog2(N + WORD_W);

  localparam logic [WORD_W-1:0] FULL_MASK = '1;
  localparam logic [WORD_W-1:0] LAST_MASK = FULL_MASK >> (WORD_W - LAST_W);

  state_t            st_q [2];
  state_t            st_d [2];
  bank_sel_t         ld_sel;
  bank_sel_t         pres_sel;
  logic [BEAT_W-1:0] beat_cnt;
  logic [CH_W-1:0]   ch_cnt;
  logic [PIX_W-1:0]  pix_idx;
  logic [WORD_W-1:0] wr_mask;
  logic              last_beat;
  logic              last_ch;
  logic              in_ready_c;
  logic              img_valid_c;
  logic              accept;
  logic              frame_done;
  logic              rel;
  logic [N-1:0]      img_a [0:IC-1];

  assign last_beat  = (beat_cnt == BEAT_W'(BPC - 1));
  assign last_ch    = (ch_cnt == CH_W'(IC - 1));
  assign pix_idx    = PIX_W'(beat_cnt) * PIX_W'(WORD_W);
  assign wr_mask    = last_beat ? LAST_MASK : FULL_MASK;
  // A beat offered together with clear is dropped.
  assign accept     = in_ready_c && bus.in_valid && !clear;
  assign frame_done = accept && last_beat && last_ch;

`ifdef FMAP_LOADER_DBL_BUF_EN
  // Only ack releases the presented frame; clear touches the loading bank only.
  assign rel = img_valid_c && bus.img_ack;

  // Banks fill and present in strict alternation, so each pointer just toggles.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_sel   <= BANK_A;
      pres_sel <= BANK_A;
    end else begin
      if (frame_done) ld_sel <= bank_sel_t'(~ld_sel);
      if (rel)        pres_sel <= bank_sel_t'(~pres_sel);
    end
  end
`else
  // Single bank: clear while full acts as a release, alone or with ack.
  assign rel      = img_valid_c && (bus.img_ack || clear);
  assign ld_sel   = BANK_A;
  assign pres_sel = BANK_A;
`endif

  // Per-bank state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) st_q[b] <= LOAD;
    end else begin
      for (int b = 0; b < 2; b++) st_q[b] <= st_d[b];
    end
  end

  // Next state: release empties the presented bank, completion fills the loading one.
  always_comb begin
    st_d = st_q;
    if (rel)        st_d[pres_sel] = LOAD;
    if (frame_done) st_d[ld_sel]   = FULL;
  end

  // Handshake outputs depend on bank state only.
  always_comb begin
    in_ready_c  = (st_q[ld_sel] == LOAD);
    img_valid_c = (st_q[pres_sel] == FULL);
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.img_valid = img_valid_c;

  // Beat / channel position within the frame being loaded.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      beat_cnt <= '0;
      ch_cnt   <= '0;
    end else if (accept) begin
      if (last_beat) begin
        beat_cnt <= '0;
        ch_cnt   <= last_ch ? '0 : ch_cnt + CH_W'(1);
      end else begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
      end
    end
  end

  fmap_bank #(
    .IC(IC), .N(N), .WORD_W(WORD_W), .CH_W(CH_W), .PIX_W(PIX_W)
  ) u_bank_a (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept && (ld_sel == BANK_A)),
    .wr_ch   (ch_cnt),
    .wr_pix  (pix_idx),
    .wr_data (bus.in_data),
    .wr_mask (wr_mask),
    .rd_img  (img_a)
  );

`ifdef FMAP_LOADER_DBL_BUF_EN
  logic [N-1:0] img_b [0:IC-1];

  fmap_bank #(
    .IC(IC), .N(N), .WORD_W(WORD_W), .CH_W(CH_W), .PIX_W(PIX_W)
  ) u_bank_b (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept && (ld_sel == BANK_B)),
    .wr_ch   (ch_cnt),
    .wr_pix  (pix_idx),
    .wr_data (bus.in_data),
    .wr_mask (wr_mask),
    .rd_img  (img_b)
  );

  // Present whichever bank is currently selected for the conv core.
  always_comb begin
    for (int c = 0; c < IC; c++)
      bus.img_out[c] = (pres_sel == BANK_A) ? img_a[c] : img_b[c];
  end
`else
  // Single bank drives the conv core directly.
  always_comb begin
    for (int c = 0; c < IC; c++) bus.img_out[c] = img_a[c];
  end
`endif

endmodule

// File: tb/tb_fmap_loader.sv
// Directed bench for fmap_loader (default parameters). Build with
// FMAP_LOADER_DBL_BUF_EN defined to exercise the double-buffer variant.
module tb_fmap_loader;

  localparam int IC       = 8;
  localparam int IMG_SIZE = 30;
  localparam int WORD_W   = 8;
  localparam int N        = IMG_SIZE * IMG_SIZE;
  localparam int BPC      = 113;
  localparam int FRAME    = IC * BPC;
  localparam int WAIT_MAX = 64;

  logic clk = 1'b0;
  logic rst;
  logic clear;

  always #5 clk = ~clk;

  fmap_loader_if #(.IC(IC), .IMG_SIZE(IMG_SIZE), .WORD_W(WORD_W)) bus ();

  fmap_loader #(.IC(IC), .IMG_SIZE(IMG_SIZE), .WORD_W(WORD_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int stall_cycles = 0;
  logic [7:0] sent [0:1][0:FRAME-1];

  typedef struct {
    int   kind;
    int   ch;
    int   bit_i;
    logic exp;
  } vec_t;

  localparam int NVEC = 19;
  vec_t tbl [NVEC];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] beat_val(input int kind, input int k);
    case (kind)
      0:       return k[7:0];
      1:       return ((k % BPC) == BPC - 1) ? 8'hFF : 8'h00;
      2:       return 8'hFF;
      3:       return 8'($urandom);
      default: return 8'(k * 7 + 3);
    endcase
  endfunction

  task automatic send_beat(input logic [7:0] d);
    int t;
    t = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < WAIT_MAX) begin
      @(posedge clk);
      #1;
      t++;
      stall_cycles++;
    end
    if (!bus.in_ready) begin
      errors++;
      checks++;
      $display("FAIL beat_wait: in_ready stayed %0b for %0d cycles, required 1", bus.in_ready, t);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_beats(input int kind, input int slot, input int first,
                            input int count, input bit gaps);
    logic [7:0] v;
    for (int k = first; k < first + count; k++) begin
      v = beat_val(kind, k);
      sent[slot][k] = v;
      if (gaps) idle($urandom_range(0, 2));
      send_beat(v);
    end
  endtask

  // Whole frame; optionally checks img_valid is low before the last beat and high right after.
  task automatic load_frame(input int kind, input int slot, input bit gaps, input bit lat);
    send_beats(kind, slot, 0, FRAME - 1, gaps);
    if (lat) chk("valid_before_last", bus.img_valid, 1'b0);
    send_beats(kind, slot, FRAME - 1, 1, gaps);
    if (lat) chk("valid_after_last", bus.img_valid, 1'b1);
  endtask

  task automatic chk_frame(input string nm, input int slot);
    logic [N-1:0] e;
    for (int c = 0; c < IC; c++) begin
      for (int j = 0; j < N; j++) e[j] = sent[slot][c * BPC + j / WORD_W][j % WORD_W];
      checks++;
      if (bus.img_out[c] !== e) begin
        errors++;
        $display("FAIL %s ch%0d: got %h expected %h", nm, c, bus.img_out[c], e);
      end
    end
  endtask

  task automatic run_table(input int kind);
    for (int i = 0; i < NVEC; i++) begin
      if (tbl[i].kind == kind)
        chk($sformatf("vec%0d_ch%0d_bit%0d", i, tbl[i].ch, tbl[i].bit_i),
            bus.img_out[tbl[i].ch][tbl[i].bit_i], tbl[i].exp);
    end
  endtask

  task automatic pulse(input logic ack, input logic clr);
    bus.img_ack = ack;
    clear       = clr;
    @(posedge clk);
    #1;
    bus.img_ack = 1'b0;
    clear       = 1'b0;
  endtask

  task automatic chk_empty(input string nm);
    logic nz;
    nz = 1'b0;
    for (int c = 0; c < IC; c++) nz |= |bus.img_out[c];
    chk({nm, "_valid"}, bus.img_valid, 1'b0);
    chk({nm, "_ready"}, bus.in_ready, 1'b1);
    chk({nm, "_img_nonzero"}, nz, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    // Hand-computed bits: kind 0 beat k = k[7:0]; kind 1 only last-of-channel beats are 0xFF.
    tbl[0]  = '{0, 0, 0,   1'b0};
    tbl[1]  = '{0, 0, 8,   1'b1};
    tbl[2]  = '{0, 0, 17,  1'b1};
    tbl[3]  = '{0, 0, 899, 1'b0};
    tbl[4]  = '{0, 1, 0,   1'b1};
    tbl[5]  = '{0, 1, 1,   1'b0};
    tbl[6]  = '{0, 1, 4,   1'b1};
    tbl[7]  = '{0, 2, 55,  1'b1};
    tbl[8]  = '{0, 3, 100, 1'b1};
    tbl[9]  = '{0, 7, 0,   1'b1};
    tbl[10] = '{0, 7, 3,   1'b0};
    tbl[11] = '{0, 7, 898, 1'b1};
    tbl[12] = '{1, 0, 896, 1'b1};
    tbl[13] = '{1, 0, 899, 1'b1};
    tbl[14] = '{1, 0, 895, 1'b0};
    tbl[15] = '{1, 1, 0,   1'b0};
    tbl[16] = '{1, 1, 3,   1'b0};
    tbl[17] = '{1, 3, 897, 1'b1};
    tbl[18] = '{1, 7, 899, 1'b1};

    rst          = 1'b1;
    clear        = 1'b0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.img_ack  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_empty("reset");

`ifndef FMAP_LOADER_DBL_BUF_EN
    // Basic frame, in_valid held high.
    load_frame(0, 0, 1'b0, 1'b1);
    chk("full_ready", bus.in_ready, 1'b0);
    run_table(0);
    chk_frame("basic", 0);
    pulse(1'b1, 1'b0);
    chk("ack_valid", bus.img_valid, 1'b0);
    chk("ack_ready", bus.in_ready, 1'b1);

    // Last-beat masking; release with clear alone.
    load_frame(1, 0, 1'b0, 1'b1);
    run_table(1);
    chk_frame("mask", 0);
    pulse(1'b0, 1'b1);
    chk("clear_release_valid", bus.img_valid, 1'b0);

    // Gaps, then extra beats offered while full must be refused.
    load_frame(3, 0, 1'b1, 1'b1);
    busy = 0;
    bus.in_data  = 8'hAA;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready) busy++;
      idle(1);
    end
    bus.in_valid = 1'b0;
    chk("full_ready_cycles", busy, 0);
    chk("full_held_valid", bus.img_valid, 1'b1);
    chk_frame("held", 0);
    pulse(1'b1, 1'b0);
    // Frame 2, with an ack pulse mid-load that must be ignored.
    send_beats(4, 0, 0, 450, 1'b0);
    pulse(1'b1, 1'b0);
    send_beats(4, 0, 450, FRAME - 451, 1'b0);
    chk("f2_valid_before_last", bus.img_valid, 1'b0);
    send_beats(4, 0, FRAME - 1, 1, 1'b0);
    chk("f2_valid", bus.img_valid, 1'b1);
    chk_frame("frame2", 0);
    pulse(1'b1, 1'b1);
    chk("dual_release_valid", bus.img_valid, 1'b0);
    chk("dual_release_ready", bus.in_ready, 1'b1);

    // clear after 300 beats, with a beat offered in the clear cycle.
    send_beats(0, 0, 0, 300, 1'b0);
    bus.in_data  = 8'h55;
    bus.in_valid = 1'b1;
    clear        = 1'b1;
    idle(1);
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    chk("clear_ready", bus.in_ready, 1'b1);
    load_frame(2, 0, 1'b0, 1'b1);
    chk_frame("ones", 0);

    // Reset while full, then reset mid-load.
    do_reset();
    chk_empty("rst_full");
    send_beats(3, 0, 0, 500, 1'b0);
    do_reset();
    chk_empty("rst_load");
    load_frame(0, 0, 1'b0, 1'b1);
    chk_frame("after_rst", 0);
`else
    // Back-to-back frames with a long-delayed ack.
    load_frame(0, 0, 1'b0, 1'b1);
    chk("f1_ready", bus.in_ready, 1'b1);
    run_table(0);
    stall_cycles = 0;
    load_frame(4, 1, 1'b0, 1'b0);
    chk("f2_stalls", stall_cycles, 0);
    chk("both_full_ready", bus.in_ready, 1'b0);
    chk("both_full_valid", bus.img_valid, 1'b1);
    chk_frame("dbl_f1", 0);
    idle(2000);
    chk_frame("dbl_f1_held", 0);
    pulse(1'b1, 1'b0);
    chk("swap_valid", bus.img_valid, 1'b1);
    chk("swap_ready", bus.in_ready, 1'b1);
    chk_frame("dbl_f2", 1);
    pulse(1'b1, 1'b0);
    chk("drain_valid", bus.img_valid, 1'b0);

    // clear discards only the partial loading bank.
    send_beats(3, 0, 0, 100, 1'b0);
    pulse(1'b0, 1'b1);
    load_frame(2, 0, 1'b0, 1'b1);
    chk_frame("dbl_ones", 0);
    do_reset();
    chk_empty("dbl_rst");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
